// File: rtl/mcpu_ctrl_unit.sv
// Multicycle MCPU control FSM: sequences one instruction at a time and drives
// every datapath control input as a Moore function of the current state.
module mcpu_ctrl_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst,
    input  logic        zero,
    input  logic        MIO_ready,
    output logic        IorD,
    output logic        IRWrite,
    output logic [1:0]  RegDst,
    output logic        RegWrite,
    output logic [1:0]  MemtoReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Branch,
    output logic [3:0]  ALU_operation,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        CPU_MIO,
    output logic [4:0]  state,
    output logic        illegal
);
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] F_JR    = 6'b001000;

    typedef enum logic [4:0] {
        S_IF  = 5'd0,  S_ID  = 5'd1,  S_MA  = 5'd2,  S_MR  = 5'd3,
        S_LW  = 5'd4,  S_MW  = 5'd5,  S_RX  = 5'd6,  S_RW  = 5'd7,
        S_BR  = 5'd8,  S_JMP = 5'd9,  S_JAL = 5'd10, S_JR  = 5'd11,
        S_IX  = 5'd12, S_IW  = 5'd13, S_LUI = 5'd14
    } state_t;

    state_t     st, id_next;
    logic [5:0] opcode, funct;
    logic [3:0] rx_op, ix_op;
    logic       r_legal, id_illegal;
    logic       unused_ok;

    assign opcode    = Inst[31:26];
    assign funct     = Inst[5:0];
    // The ALU zero flag and the operand fields are consumed by the datapath, not here.
    assign unused_ok = ^{zero, Inst[25:6]};

    always_comb begin
        rx_op   = ALU_ADD;
        r_legal = 1'b1;
        case (funct)
            6'b100000: rx_op = ALU_ADD;
            6'b100010: rx_op = ALU_SUB;
            6'b100100: rx_op = ALU_AND;
            6'b100101: rx_op = ALU_OR;
            6'b100110: rx_op = ALU_XOR;
            6'b100111: rx_op = ALU_NOR;
            6'b101010: rx_op = ALU_SLT;
            default:   r_legal = 1'b0;
        endcase
        case (opcode)
            OP_ANDI: ix_op = ALU_AND;
            OP_ORI:  ix_op = ALU_OR;
            OP_SLTI: ix_op = ALU_SLT;
            default: ix_op = ALU_ADD;
        endcase
    end

    always_comb begin
        id_next    = S_IF;
        id_illegal = 1'b0;
        case (opcode)
            OP_LW, OP_SW:  id_next = S_MA;
            OP_R: begin
                if (funct == F_JR)  id_next = S_JR;
                else if (r_legal)   id_next = S_RX;
                else                id_illegal = 1'b1;
            end
            OP_BEQ, OP_BNE: id_next = S_BR;
            OP_J:           id_next = S_JMP;
            OP_JAL:         id_next = S_JAL;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: id_next = S_IX;
            OP_LUI:         id_next = S_LUI;
            default:        id_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st <= S_IF;
        end else begin
            case (st)
                S_IF:    if (MIO_ready) st <= S_ID;
                S_ID:    st <= id_next;
                S_MA:    st <= (opcode == OP_LW) ? S_MR : S_MW;
                S_MR:    if (MIO_ready) st <= S_LW;
                S_MW:    if (MIO_ready) st <= S_IF;
                S_RX:    st <= S_RW;
                S_IX:    st <= S_IW;
                default: st <= S_IF;
            endcase
        end
    end

    // Outputs are gated by reset so nothing can write while the core is held.
    always_comb begin
        IorD = 1'b0; IRWrite = 1'b0; RegDst = 2'd0; RegWrite = 1'b0;
        MemtoReg = 2'd0; ALUSrcA = 1'b0; ALUSrcB = 2'd0; PCSource = 2'd0;
        PCWrite = 1'b0; PCWriteCond = 1'b0; Branch = 1'b0;
        ALU_operation = ALU_AND; MemRead = 1'b0; MemWrite = 1'b0; illegal = 1'b0;
        if (reset) begin
            case (st)
                S_IF: begin
                    MemRead = 1'b1; IRWrite = 1'b1; ALUSrcB = 2'd1;
                    ALU_operation = ALU_ADD; PCWrite = 1'b1;
                end
                S_ID: begin
                    ALUSrcB = 2'd3; ALU_operation = ALU_ADD; illegal = id_illegal;
                end
                S_MA: begin
                    ALUSrcA = 1'b1; ALUSrcB = 2'd2; ALU_operation = ALU_ADD;
                end
                S_MR:  begin IorD = 1'b1; MemRead = 1'b1; end
                S_LW:  begin MemtoReg = 2'd1; RegWrite = 1'b1; end
                S_MW:  begin IorD = 1'b1; MemWrite = 1'b1; end
                S_RX:  begin ALUSrcA = 1'b1; ALU_operation = rx_op; end
                S_RW:  begin RegDst = 2'd1; RegWrite = 1'b1; end
                S_BR: begin
                    ALUSrcA = 1'b1; ALU_operation = ALU_SUB; PCWriteCond = 1'b1;
                    PCSource = 2'd1; Branch = (opcode == OP_BEQ);
                end
                S_JMP: begin PCSource = 2'd2; PCWrite = 1'b1; end
                S_JAL: begin
                    PCSource = 2'd2; PCWrite = 1'b1; RegDst = 2'd2;
                    MemtoReg = 2'd3; RegWrite = 1'b1;
                end
                S_JR:  begin ALUSrcA = 1'b1; ALU_operation = ALU_ADD; PCWrite = 1'b1; end
                S_IX:  begin ALUSrcA = 1'b1; ALUSrcB = 2'd2; ALU_operation = ix_op; end
                S_IW:  RegWrite = 1'b1;
                S_LUI: begin MemtoReg = 2'd2; RegWrite = 1'b1; end
                default: ;
            endcase
        end
    end

    assign CPU_MIO = MemRead | MemWrite;
    assign state   = st;
endmodule
